// File: rtl/fp_round_pack.sv
// fp_round_pack: output stage of the linear-to-float converter.
// It rounds a {sign, exponent, significand, round bit} word half-up, carrying
// into the exponent and clipping to the largest code. It then packs the result
// into an 8-bit float {S, E[2:0], F[3:0]}. The word passes through a 2-stage
// valid/ready pipeline, and a counter records how many words saturated.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   in_valid/ready    upstream handshake (in_ready is combinational from out_ready)
//   in_sign           sign of the sample, passed through untouched
//   in_exponent       3-bit exponent from the converter
//   in_significand    4-bit significand from the converter
//   in_round          magnitude bit just below the significand LSB
//   out_valid/ready   downstream handshake
//   out_float         packed {sign, exponent, significand}
//   sat_count         saturated words delivered downstream (sticks at all-ones)
//   sat_clear         synchronous clear of sat_count, wins over an increment
module fp_round_pack #(
    parameter bit ROUND_EN  = 1'b1,
    parameter int SAT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sign,
    input  logic [2:0]           in_exponent,
    input  logic [3:0]           in_significand,
    input  logic                 in_round,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [7:0]           out_float,
    output logic [SAT_CNT_W-1:0] sat_count,
    input  logic                 sat_clear
);

    localparam logic [SAT_CNT_W-1:0] SAT_MAX = '1;

    logic       s1_valid;
    logic       s1_sign;
    logic [2:0] s1_e;
    logic [3:0] s1_f;
    logic       s1_sat;
    logic       s2_sat;

    logic       s1_en;
    logic       s2_en;

    logic       rnd;
    logic [4:0] sum;
    logic [2:0] nx_e;
    logic [3:0] nx_f;
    logic       nx_sat;

    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    always_comb begin
        rnd    = ROUND_EN & in_round;
        sum    = {1'b0, in_significand} + {4'd0, rnd};
        nx_e   = in_exponent;
        nx_f   = sum[3:0];
        // A dropped round bit on the top code still counts as clipping,
        // even when rounding is disabled.
        nx_sat = (in_exponent == 3'd7) && (in_significand == 4'hF) && in_round;
        if (sum[4]) begin
            if (in_exponent == 3'd7) begin
                nx_f   = 4'hF;
                nx_sat = 1'b1;
            end else begin
                nx_e = in_exponent + 3'd1;
                nx_f = 4'b1000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_e     <= 3'd0;
            s1_f     <= 4'd0;
            s1_sat   <= 1'b0;
        end else if (s1_en) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign <= in_sign;
                s1_e    <= nx_e;
                s1_f    <= nx_f;
                s1_sat  <= nx_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_float <= 8'h00;
            s2_sat    <= 1'b0;
        end else if (s2_en) begin
            out_valid <= s1_valid;
            out_float <= {s1_sign, s1_e, s1_f};
            s2_sat    <= s1_valid & s1_sat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clear) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && s2_sat && (sat_count != SAT_MAX)) begin
            sat_count <= sat_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fp_round_pack.sv
// Directed and scoreboard bench for fp_round_pack. It uses a rounding instance
// (dut) and a truncating instance (dut_t) with a 2-bit saturation counter.
// Both instances share their inputs.
module tb_fp_round_pack;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_sign;
    logic [2:0] in_exponent;
    logic [3:0] in_significand;
    logic       in_round;
    logic       out_ready;
    logic       sat_clear;

    logic       in_ready, out_valid;
    logic [7:0] out_float;
    logic [7:0] sat_count;
    logic       t_in_ready, t_out_valid;
    logic [7:0] t_out_float;
    logic [1:0] t_sat_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_round_pack #(.ROUND_EN(1'b1), .SAT_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exponent(in_exponent), .in_significand(in_significand),
        .in_round(in_round), .out_valid(out_valid), .out_ready(out_ready),
        .out_float(out_float), .sat_count(sat_count), .sat_clear(sat_clear)
    );

    fp_round_pack #(.ROUND_EN(1'b0), .SAT_CNT_W(2)) dut_t (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_sign(in_sign), .in_exponent(in_exponent), .in_significand(in_significand),
        .in_round(in_round), .out_valid(t_out_valid), .out_ready(out_ready),
        .out_float(t_out_float), .sat_count(t_sat_count), .sat_clear(sat_clear)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // w = {sign, exponent[2:0], significand[3:0], round}
    task automatic drive(input logic v, input logic [8:0] w);
        in_valid       = v;
        in_sign        = w[8];
        in_exponent    = w[7:5];
        in_significand = w[4:1];
        in_round       = w[0];
    endtask

    // Converter model: magnitude -> {E, F, R}, leading one kept in F
    function automatic logic [7:0] conv(input logic [10:0] m);
        int p;
        p = 4;
        if (m < 11'd16) return {3'd0, m[3:0], 1'b0};
        for (int i = 4; i <= 10; i++) if (m[i]) p = i;
        return {3'(p - 3), 4'(m >> (p - 3)), m[p - 4]};
    endfunction

    // Expected {sat, float}: add half an LSB to the magnitude, then truncate
    function automatic logic [8:0] expect_word(input logic s, input logic [10:0] m);
        logic [7:0]  c;
        logic [11:0] m2;
        c  = conv(m);
        m2 = {1'b0, m};
        if (c[0]) m2 = m2 + (12'd1 << (c[7:5] - 3'd1));
        if (m2[11]) return {1'b1, s, 7'h7F};
        c = conv(m2[10:0]);
        return {1'b0, s, c[7:1]};
    endfunction

    task automatic test_reset();
        rst = 1'b1; out_ready = 1'b1; sat_clear = 1'b0;
        drive(1'b0, 9'd0);
        repeat (3) tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_float !== 8'h00) begin errors++; $display("FAIL reset_out_float: got %h expected 00", out_float); end
        checks++; if (sat_count !== 8'd0) begin errors++; $display("FAIL reset_sat_count: got %0d expected 0", sat_count); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (t_sat_count !== 2'd0) begin errors++; $display("FAIL reset_t_sat_count: got %0d expected 0", t_sat_count); end
    endtask

    task automatic test_no_round();
        out_ready = 1'b1;
        drive(1'b1, {1'b0, 3'd3, 4'h9, 1'b0});
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL noround_in_ready: got %b expected 1", in_ready); end
        tick();
        drive(1'b0, 9'd0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL noround_early_valid: got %b expected 0", out_valid); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL noround_valid: got %b expected 1", out_valid); end
        checks++; if (out_float !== 8'h39) begin errors++; $display("FAIL noround_float: got %h expected 39", out_float); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL noround_in_ready2: got %b expected 1", in_ready); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL noround_dup: got %b expected 0", out_valid); end
    endtask

    task automatic test_round();
        logic [8:0] vec [6];
        logic [7:0] exp_r [6];
        logic [7:0] exp_t [6];
        vec[0] = {1'b0, 3'd2, 4'hF, 1'b1}; exp_r[0] = 8'h38; exp_t[0] = 8'h2F;
        vec[1] = {1'b1, 3'd5, 4'hA, 1'b1}; exp_r[1] = 8'hDB; exp_t[1] = 8'hDA;
        vec[2] = {1'b0, 3'd4, 4'hF, 1'b1}; exp_r[2] = 8'h58; exp_t[2] = 8'h4F;
        vec[3] = {1'b0, 3'd0, 4'h0, 1'b0}; exp_r[3] = 8'h00; exp_t[3] = 8'h00;
        vec[4] = {1'b1, 3'd0, 4'h0, 1'b0}; exp_r[4] = 8'h80; exp_t[4] = 8'h80;
        vec[5] = {1'b0, 3'd7, 4'hE, 1'b1}; exp_r[5] = 8'h7F; exp_t[5] = 8'h7E;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vec[i]);
            tick();
            drive(1'b0, 9'd0);
            tick();
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL round_valid[%0d]: got %b expected 1", i, out_valid); end
            checks++; if (out_float !== exp_r[i]) begin errors++; $display("FAIL round_float[%0d]: got %h expected %h", i, out_float, exp_r[i]); end
            checks++; if (t_out_float !== exp_t[i]) begin errors++; $display("FAIL trunc_float[%0d]: got %h expected %h", i, t_out_float, exp_t[i]); end
        end
        tick();
        #1;
        checks++; if (sat_count !== 8'd0) begin errors++; $display("FAIL round_no_sat: got %0d expected 0", sat_count); end
        checks++; if (t_sat_count !== 2'd0) begin errors++; $display("FAIL trunc_no_sat: got %0d expected 0", t_sat_count); end
    endtask

    task automatic test_saturation();
        int exp_t;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, {1'b0, 3'd7, 4'hF, 1'b1});
            tick();
            drive(1'b0, 9'd0);
            tick();
            #1;
            checks++; if (out_float !== 8'h7F) begin errors++; $display("FAIL sat_float[%0d]: got %h expected 7f", i, out_float); end
            checks++; if (t_out_float !== 8'h7F) begin errors++; $display("FAIL sat_t_float[%0d]: got %h expected 7f", i, t_out_float); end
            tick();
            #1;
            exp_t = (i + 1 > 3) ? 3 : i + 1;
            checks++; if (sat_count !== 8'(i + 1)) begin errors++; $display("FAIL sat_count[%0d]: got %0d expected %0d", i, sat_count, i + 1); end
            checks++; if (t_sat_count !== 2'(exp_t)) begin errors++; $display("FAIL sat_t_count[%0d]: got %0d expected %0d", i, t_sat_count, exp_t); end
        end
        drive(1'b1, {1'b0, 3'd7, 4'hF, 1'b1});
        tick();
        drive(1'b0, 9'd0);
        tick();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL satclr_valid: got %b expected 1", out_valid); end
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        #1;
        checks++; if (sat_count !== 8'd0) begin errors++; $display("FAIL satclr_count: got %0d expected 0", sat_count); end
        checks++; if (t_sat_count !== 2'd0) begin errors++; $display("FAIL satclr_t_count: got %0d expected 0", t_sat_count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL satclr_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [8:0] w [6];
        logic [7:0] e [6];
        int idx, oidx;
        logic prev_stall;
        logic [7:0] held;
        w[0] = {1'b0, 3'd1, 4'h1, 1'b0}; e[0] = 8'h11;
        w[1] = {1'b0, 3'd2, 4'h2, 1'b0}; e[1] = 8'h22;
        w[2] = {1'b1, 3'd3, 4'h3, 1'b0}; e[2] = 8'hB3;
        w[3] = {1'b0, 3'd4, 4'h4, 1'b1}; e[3] = 8'h45;
        w[4] = {1'b0, 3'd5, 4'hF, 1'b1}; e[4] = 8'h68;
        w[5] = {1'b1, 3'd6, 4'h6, 1'b0}; e[5] = 8'hE6;
        idx = 0; oidx = 0; prev_stall = 1'b0; held = 8'h00;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = !(c >= 3 && c <= 7);
            if (idx < 6) drive(1'b1, w[idx]); else drive(1'b0, 9'd0);
            #1;
            if (prev_stall) begin
                checks++; if (out_valid !== 1'b1 || out_float !== held) begin errors++; $display("FAIL bp_stable c%0d: got %b/%h expected 1/%h", c, out_valid, out_float, held); end
            end
            if (c >= 3 && c <= 7) begin
                checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b expected 0", c, in_ready); end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (oidx >= 6) begin errors++; $display("FAIL bp_extra c%0d: got %h expected none", c, out_float); end
                else if (out_float !== e[oidx]) begin errors++; $display("FAIL bp_order[%0d]: got %h expected %h", oidx, out_float, e[oidx]); end
                oidx++;
            end
            if (in_valid && in_ready) idx++;
            prev_stall = out_valid && !out_ready;
            held = out_float;
        end
        drive(1'b0, 9'd0);
        checks++; if (oidx != 6) begin errors++; $display("FAIL bp_out_count: got %0d expected 6", oidx); end
        checks++; if (idx != 6) begin errors++; $display("FAIL bp_in_count: got %0d expected 6", idx); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(1'b1, {1'b0, 3'd7, 4'hF, 1'b1});
        tick();
        drive(1'b0, 9'd0);
        tick();
        tick();
        #1;
        checks++; if (sat_count !== 8'd1) begin errors++; $display("FAIL rstmid_pre_count: got %0d expected 1", sat_count); end
        out_ready = 1'b0;
        drive(1'b1, {1'b0, 3'd1, 4'h1, 1'b0});
        tick();
        drive(1'b1, {1'b0, 3'd3, 4'h3, 1'b0});
        tick();
        drive(1'b0, 9'd0);
        #1;
        checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_full: got %b/%b expected 1/0", out_valid, in_ready); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
        checks++; if (sat_count !== 8'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", sat_count); end
        checks++; if (out_float !== 8'h00) begin errors++; $display("FAIL rstmid_float: got %h expected 00", out_float); end
        out_ready = 1'b1;
        drive(1'b1, {1'b0, 3'd2, 4'h1, 1'b0});
        tick();
        drive(1'b0, 9'd0);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale: got %b expected 0", out_valid); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b1 || out_float !== 8'h21) begin errors++; $display("FAIL rstmid_first: got %b/%h expected 1/21", out_valid, out_float); end
        tick();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_random();
        logic [8:0]  q [$];
        logic [8:0]  cur, got_exp;
        logic [7:0]  ef;
        logic [10:0] m;
        logic        s;
        int          mode, exp_cnt;
        sat_clear = 1'b1;
        tick();
        sat_clear = 1'b0;
        exp_cnt = 0;
        cur = 9'd0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 3) != 0);
            if (!(in_valid && !in_ready) || !in_valid) begin
                s    = 1'($urandom_range(0, 1));
                mode = $urandom_range(0, 3);
                if (mode == 0)      m = 11'($urandom_range(0, 31));
                else if (mode == 1) m = 11'(2047 - $urandom_range(0, 100));
                else                m = 11'($urandom_range(0, 2047));
                ef  = conv(m);
                cur = expect_word(s, m);
                drive(($urandom_range(0, 4) != 0), {s, ef});
            end
            #1;
            if (out_valid && out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_extra c%0d: got %h expected none", c, out_float);
                end else begin
                    got_exp = q.pop_front();
                    if (out_float !== got_exp[7:0]) begin errors++; $display("FAIL rand_word c%0d: got %h expected %h", c, out_float, got_exp[7:0]); end
                    if (got_exp[8] && exp_cnt < 255) exp_cnt++;
                end
            end
            if (in_valid && in_ready) q.push_back(cur);
        end
        @(negedge clk);
        drive(1'b0, 9'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL rand_drain_extra: got %h expected none", out_float);
                end else begin
                    got_exp = q.pop_front();
                    if (out_float !== got_exp[7:0]) begin errors++; $display("FAIL rand_drain: got %h expected %h", out_float, got_exp[7:0]); end
                    if (got_exp[8] && exp_cnt < 255) exp_cnt++;
                end
            end
            tick();
        end
        #1;
        checks++; if (q.size() != 0) begin errors++; $display("FAIL rand_lost: got %0d pending expected 0", q.size()); end
        checks++; if (sat_count !== 8'(exp_cnt)) begin errors++; $display("FAIL rand_sat_count: got %0d expected %0d", sat_count, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_no_round();
        test_round();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
